ram_loader: RTL and testbench
=============================

# ram_loader

Byte-stream program loader that sits directly upstream of the 256×8 program/data RAM on the CDEC board. It takes bytes from the serial receiver, writes a length-prefixed image into consecutive RAM addresses, and holds the CPU in reset while loading. It then reports done or error. It drives the RAM's `adrs`/`data`/`wr_en` port and owns it whenever `busy` is high.

## Interface
Parameters:
- `BASE_ADRS`, default 8'h00: first RAM address written.
- `TIMEOUT`, default 50000: maximum clocks allowed between bytes while loading. 0 disables the timeout.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`.
- `rx_data`  in  8  received byte; valid only with `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `adrs`  out  8  RAM address.
- `data`  out  8  RAM write data.
- `wr_en`  out  1  RAM write enable; high for exactly one cycle per payload byte.
- `cpu_reset`  out  1  holds the CPU in reset while loading or after an error.
- `busy`  out  1  load in progress.
- `done`  out  1  level; the last load completed successfully.
- `error`  out  1  level; the last load failed (timeout or checksum).

## Operation
- States: IDLE, COUNT, DATA, CHECK (only with the macro), DONE, ERR.
- Reset values: all outputs 0. State = IDLE; pointer = BASE_ADRS; byte counter = 0; timeout counter = 0; checksum accumulator = 0.
- IDLE, DONE, ERR + `start` → COUNT.
  - On entry: set `busy` and `cpu_reset`; clear `done`/`error`; reload the pointer with BASE_ADRS; clear the accumulator.
- COUNT + `rx_valid` → DATA. Byte counter = `rx_data`; the value 0 means 256 bytes.
- DATA + `rx_valid`:
  - Register `adrs`=pointer, `data`=`rx_data`, `wr_en`=1 for the next cycle.
  - Pointer increments modulo 256, so wrap FF→00 is legal. The counter decrements and the accumulator adds `rx_data` mod 256.
  - After the last byte: go to CHECK if compiled in, otherwise DONE.
- DONE: `busy`=0, `cpu_reset`=0, `done`=1.
- ERR: `busy`=0, `cpu_reset` stays 1, `error`=1.
- Timeout:
  - In COUNT, DATA or CHECK, the timeout counter increments every cycle without `rx_valid` and clears on `rx_valid`.
  - When it reaches TIMEOUT (if TIMEOUT≠0), go to ERR. No further writes occur.
- `rx_valid` in IDLE, DONE or ERR is ignored: no write, no state change.
- `start` while `busy` is ignored.
- `start` and `rx_valid` in the same cycle from IDLE: the start is accepted and the byte is dropped.
- `reset` mid-load: immediate return to reset values; the partial image is left in RAM.

## Timing
- `wr_en` rises the cycle after the accepted `rx_valid` and falls the cycle after that.
- `adrs`/`data` are registered on the rising edge and remain stable through the falling edge at which the RAM samples them. `adrs` holds its last value when not writing.
- Latency from last payload byte strobe to `done`=1:
  - 2 cycles without the macro (write cycle, then DONE).
  - Without the macro, `wr_en` and `done` are never high in the same cycle.
- `cpu_reset` deasserts in the same cycle `done` asserts.
- Back-to-back `rx_valid` on consecutive cycles must be supported: one write per cycle, no drops.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the payload, one extra byte is expected in CHECK.
  - If (accumulator + byte) mod 256 == 0, go to DONE; otherwise go to ERR. The checksum byte is never written to RAM.
  - Latency from checksum strobe to `done`/`error` is 1 cycle.
- Not defined: the CHECK state and accumulator are absent, and DATA goes directly to DONE.

## Test plan
- Reset, then `start`, then bytes 03, 01, 07, 06:
  - Writes 01@00, 07@01, 06@02 with one `wr_en` pulse each.
  - `done`=1 and `cpu_reset`=0 two cycles after the last strobe.
- BASE_ADRS=8'hFE, count 03, bytes AA BB CC: writes AA@FE, BB@FF, CC@00 (wrap).
- Count byte 00 followed by 256 back-to-back bytes:
  - 256 writes, addresses BASE..BASE+255.
  - No dropped bytes; `done` afterwards.
- TIMEOUT=10, count 02, one byte, then silence:
  - `error`=1 after 10 idle cycles; `cpu_reset` stays 1; no second write.
  - A later `rx_valid` causes no write.
- Assert `reset` after the 2nd of 4 payload bytes: outputs return to 0 next cycle; a new `start` reloads from BASE_ADRS.
- With `LOADER_CHECKSUM_EN`, count 02, bytes 10 20:
  - Checksum D0 → `done`=1.
  - Checksum D1 → `error`=1, `cpu_reset`=1.
  - Neither checksum byte is written.

Source files
------------

// File: rtl/ram_loader.sv
// Length-prefixed byte-stream loader for the 256x8 program RAM; holds the CPU in reset while loading.
// Optional trailing checksum byte is compiled in with `define LOADER_CHECKSUM_EN.
module ram_loader #(
  parameter logic [7:0]  BASE_ADRS = 8'h00,
  parameter int unsigned TIMEOUT   = 32'd50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] adrs,
  output logic [7:0] data,
  output logic       wr_en,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  acc_q, acc_d;
`endif
  logic [7:0]  adrs_q, adrs_d;
  logic [7:0]  data_q, data_d;
  logic        wr_en_q, wr_en_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        timed_out;

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
`ifdef LOADER_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    adrs_d      = adrs_q;
    data_d      = data_q;
    wr_en_d     = 1'b0;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    timed_out   = (TIMEOUT != 32'd0) && ((tmo_q + 32'd1) == TIMEOUT);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_COUNT;
          ptr_d       = BASE_ADRS;
          tmo_d       = 32'd0;
`ifdef LOADER_CHECKSUM_EN
          acc_d       = 8'd0;
`endif
          busy_d      = 1'b1;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end else if (state_q == S_DONE) begin
          // DONE is entered during the final write cycle; the status flips one cycle later.
          busy_d      = 1'b0;
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_COUNT: begin
        if (rx_valid) begin
          cnt_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          tmo_d   = 32'd0;
          state_d = S_DATA;
        end else if (timed_out) begin
          state_d = S_ERR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          adrs_d  = ptr_q;
          data_d  = rx_data;
          wr_en_d = 1'b1;
          ptr_d   = ptr_q + 8'd1;
          cnt_d   = cnt_q - 9'd1;
          tmo_d   = 32'd0;
`ifdef LOADER_CHECKSUM_EN
          acc_d   = acc_q + rx_data;
          if (cnt_q == 9'd1) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
`else
          if (cnt_q == 9'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
`endif
        end else if (timed_out) begin
          state_d = S_ERR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          tmo_d  = 32'd0;
          busy_d = 1'b0;
          if ((acc_q + rx_data) == 8'd0) begin
            state_d     = S_DONE;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end else if (timed_out) begin
          state_d = S_ERR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= BASE_ADRS;
      cnt_q       <= 9'd0;
      tmo_q       <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      acc_q       <= 8'd0;
`endif
      adrs_q      <= 8'd0;
      data_q      <= 8'd0;
      wr_en_q     <= 1'b0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
`ifdef LOADER_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
      adrs_q      <= adrs_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign adrs      = adrs_q;
  assign data      = data_q;
  assign wr_en     = wr_en_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: expected RAM writes are queued as bytes are sent and popped as wr_en pulses appear.
module tb_ram_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] adrs;
  logic [7:0] data;
  logic       wr_en;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic        overlap_seen = 1'b0;
  logic [7:0]  b;
  logic [7:0]  sum;
  logic [15:0] exp_w;

  ram_loader #(.BASE_ADRS(8'hFE), .TIMEOUT(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .adrs     (adrs),
    .data     (data),
    .wr_en    (wr_en),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every wr_en pulse must match the oldest queued write.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      if (done === 1'b1) overlap_seen = 1'b1;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {16'd0, adrs, data}, 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check_eq("write_adrs_data", {16'd0, adrs, data}, {16'd0, exp_w});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    rx_data  = v;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ends an image so that the final status is visible on return.
  task automatic finish_image(input logic [7:0] s);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00 - s);
`else
    tick();
`endif
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_outputs", {20'd0, adrs, wr_en, cpu_reset, busy, done},
             32'd0);
    check_eq("rst_data_error", {23'd0, data, error}, 32'd0);
    reset = 1'b0;
    tick();

    // Three-byte image wrapping FE -> FF -> 00
    pulse_start();
    check_eq("start_busy", {30'd0, busy, cpu_reset}, 32'd3);
    send_byte(8'h03);
    sum = 8'd0;
    exp_q.push_back({8'hFE, 8'h01}); send_byte(8'h01); sum += 8'h01;
    exp_q.push_back({8'hFF, 8'h07}); send_byte(8'h07); sum += 8'h07;
    exp_q.push_back({8'h00, 8'h06}); send_byte(8'h06); sum += 8'h06;
`ifndef LOADER_CHECKSUM_EN
    check_eq("done_not_early", {31'd0, done}, 32'd0);
`endif
    finish_image(sum);
    check_eq("img1_done", {29'd0, done, cpu_reset, busy}, 32'd4);
    check_eq("img1_error", {31'd0, error}, 32'd0);
    check_eq("adrs_hold", {16'd0, adrs, data}, 32'h0006);
    check_eq("img1_all_written", exp_q.size(), 32'd0);

    // Byte in DONE is ignored
    send_byte(8'h55);
    tick();
    check_eq("done_ignore_rx", {30'd0, done, busy}, 32'd2);

    // 256-byte image, back to back
    pulse_start();
    check_eq("img2_start", {30'd0, busy, done}, 32'd2);
    send_byte(8'h00);
    sum = 8'd0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i) ^ 8'h5A;
      exp_q.push_back({8'hFE + 8'(i), b});
      sum += b;
      send_byte(b);
    end
    finish_image(sum);
    check_eq("img2_done", {30'd0, done, cpu_reset}, 32'd2);
    check_eq("img2_all_written", exp_q.size(), 32'd0);

    // Timeout after one of two bytes
    pulse_start();
    send_byte(8'h02);
    exp_q.push_back({8'hFE, 8'h33});
    send_byte(8'h33);
    repeat (8) tick();
    check_eq("tmo_not_early", {30'd0, error, busy}, 32'd1);
    repeat (4) tick();
    check_eq("tmo_error", {29'd0, error, cpu_reset, busy}, 32'd6);
    check_eq("tmo_done_low", {31'd0, done}, 32'd0);
    send_byte(8'h77);
    tick();
    check_eq("tmo_hold", {30'd0, error, cpu_reset}, 32'd3);
    check_eq("tmo_written", exp_q.size(), 32'd0);

    // Reset after the 2nd of 4 payload bytes
    pulse_start();
    send_byte(8'h04);
    exp_q.push_back({8'hFE, 8'h11}); send_byte(8'h11);
    exp_q.push_back({8'hFF, 8'h22}); send_byte(8'h22);
    reset = 1'b1;
    tick();
    check_eq("midrst_outputs", {20'd0, adrs, wr_en, cpu_reset, busy, done},
             32'd0);
    check_eq("midrst_data_error", {23'd0, data, error}, 32'd0);
    reset = 1'b0;
    tick();

    // Start with a simultaneous strobe: the byte must be dropped
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h05;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    send_byte(8'h01);
    exp_q.push_back({8'hFE, 8'h99});
    send_byte(8'h99);
    finish_image(8'h99);
    check_eq("reload_done", {30'd0, done, error}, 32'd2);
    check_eq("reload_written", exp_q.size(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Good and bad checksum
    pulse_start();
    send_byte(8'h02);
    exp_q.push_back({8'hFE, 8'h10}); send_byte(8'h10);
    exp_q.push_back({8'hFF, 8'h20}); send_byte(8'h20);
    send_byte(8'hD0);
    check_eq("csum_good", {29'd0, done, error, cpu_reset}, 32'd4);
    pulse_start();
    send_byte(8'h02);
    exp_q.push_back({8'hFE, 8'h10}); send_byte(8'h10);
    exp_q.push_back({8'hFF, 8'h20}); send_byte(8'h20);
    send_byte(8'hD1);
    check_eq("csum_bad", {29'd0, done, error, cpu_reset}, 32'd3);
    tick();
    check_eq("csum_written", exp_q.size(), 32'd0);
`endif

    check_eq("wr_done_overlap", {31'd0, overlap_seen}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
